aes_ecb_dec: RTL and testbench

AES_ECB_DEC -- requirements
Module: aes_ecb_dec

---
 rtl/aes_pkg.sv | 82 ++++++++
 rtl/aes_inv_sbox.sv | 16 +
 rtl/aes_sbox.sv | 16 +
 rtl/aes_ecb_dec.sv | 123 ++++++++++++
 tb/tb_aes_ecb_dec.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
// Used by both the cipher and the inverse-cipher blocks.
package aes_pkg;

  localparam int unsigned NK = 4;
  localparam int unsigned NR = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box: inverse affine transform, then GF(2^8) inverse.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pre;

  always_comb begin
    pre  = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
    dout = gf_inv(pre);
  end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: affine transform of the GF(2^8) inverse.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] inv;

  always_comb begin
    inv  = gf_inv(din);
    dout = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_ecb_dec.sv
// Iterative AES-128 ECB decryptor: one round per cycle, with a one-entry
// cache of the last fully expanded key so repeated keys skip expansion.
module aes_ecb_dec
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic         cache_valid_q;
  logic [127:0] rk [0:10];
  logic [127:0] st_q;

  logic         transfer, hit;
  logic [127:0] isr, sub, ark;
  logic [3:0]   cnt_m1;
  logic [127:0] rk_prev, rk_next;
  logic [31:0]  rot, sw, temp;
  logic [31:0]  n0, n1, n2, n3;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign transfer  = in_valid && (state_q == IDLE);
  // rk[0] doubles as the cached key copy; cache_valid guards its contents.
  assign hit       = cache_valid_q && (key == rk[0]);

  assign isr = inv_shift_rows(st_q);

  for (genvar g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (
      .din  (isr[127-8*g -: 8]),
      .dout (sub[127-8*g -: 8])
    );
  end

  // cnt_q is 0 in FINAL, so rk[cnt_q] also selects rk[0] there.
  assign ark = sub ^ rk[cnt_q];

  assign cnt_m1  = cnt_q - 4'd1;
  assign rk_prev = rk[cnt_m1];
  assign rot     = {rk_prev[23:0], rk_prev[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[31-8*g -: 8]),
      .dout (sw[31-8*g -: 8])
    );
  end

  always_comb begin
    temp    = sw ^ {RCON[cnt_q], 24'h0};
    n0      = rk_prev[127:96] ^ temp;
    n1      = rk_prev[95:64]  ^ n0;
    n2      = rk_prev[63:32]  ^ n1;
    n3      = rk_prev[31:0]   ^ n2;
    rk_next = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = hit ? INIT : KEXP;
      KEXP:    if (cnt_q == 4'(NR)) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (cnt_q == 4'd1) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cache_valid_q <= 1'b0;
      data_out      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (transfer && !hit) begin
            cnt_q         <= 4'd1;
            cache_valid_q <= 1'b0;
          end
        end
        KEXP: begin
          if (cnt_q == 4'(NR)) cache_valid_q <= 1'b1;
          else cnt_q <= cnt_q + 4'd1;
        end
        INIT:    cnt_q <= 4'(NR - 1);
        ROUND:   cnt_q <= cnt_q - 4'd1;
        FINAL:   data_out <= ark;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: begin
        if (transfer) begin
          st_q <= data_in;
          if (!hit) rk[0] <= key;
        end
      end
      KEXP:    rk[cnt_q] <= rk_next;
      INIT:    st_q <= st_q ^ rk[NR];
      ROUND:   st_q <= inv_mix_columns(ark);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_ecb_dec.sv
// Self-checking bench for aes_ecb_dec: known-answer vectors, DONE hold,
// mid-round reset and a random loopback through a behavioural encryptor.
module tb_aes_ecb_dec;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;

  int checks = 0;
  int errors = 0;

  aes_ecb_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] k;
    logic [127:0] pt;
    int           lat;
  } vec_t;

  vec_t vecs [4];
  logic [7:0] sb [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Carry-less multiply with explicit reduction by 0x11B.
  function automatic logic [7:0] m(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (m(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = m(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = m(u[4*c],8'h02) ^ m(u[4*c+1],8'h03) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ m(u[4*c+1],8'h02) ^ m(u[4*c+2],8'h03) ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ m(u[4*c+2],8'h02) ^ m(u[4*c+3],8'h03);
          s[4*c+3] = m(u[4*c],8'h03) ^ u[4*c+1] ^ u[4*c+2] ^ m(u[4*c+3],8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = u[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Drive a transfer; entered and left at 1 time unit after a rising edge.
  task automatic submit(input logic [127:0] ct, input logic [127:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_transfer", 128'(in_ready), 128'(1));
    data_in  = ct;
    key      = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = ~ct;
    key      = ~k;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_after_drain", 128'(out_valid), 128'(0));
    chk("ready_after_drain", 128'(in_ready), 128'(1));
  endtask

  task automatic run(input logic [127:0] ct, input logic [127:0] k,
                     input logic [127:0] pt, input int exp_lat, input string name);
    int lat;
    submit(ct, k);
    wait_out(lat);
    chk({name, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({name, "_data"}, data_out, pt);
    drain();
  endtask

  initial begin
    int           lat;
    logic [127:0] p, k, last_k, hold_pt;
    logic         cached;

    vecs[0] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h6bc1bee22e409f96e93d7e117393172a, 21};
    vecs[1] = '{128'hf5d3d58503b9699de785895a96fdbaaf, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'hae2d8a571e03ac9c9eb76fac45af8e51, 11};
    vecs[2] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 21};
    vecs[3] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h6bc1bee22e409f96e93d7e117393172a, 21};

    build_sbox();

    #12;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_data_out", data_out, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run(vecs[i].ct, vecs[i].k, vecs[i].pt, vecs[i].lat, $sformatf("vec%0d", i));

    // DONE must hold through out_ready=0 and ignore new in_valid pulses.
    submit(vecs[0].ct, vecs[0].k);
    wait_out(lat);
    chk("hold_latency", 128'(lat), 128'(11));
    hold_pt = data_out;
    chk("hold_first_data", hold_pt, vecs[0].pt);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      key      = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_data", data_out, vecs[0].pt);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    drain();
    run(vecs[1].ct, vecs[1].k, vecs[1].pt, 11, "after_hold_hit");

    // Reset in the middle of ROUND abandons the block and clears the cache.
    submit(vecs[2].ct, vecs[2].k);
    repeat (15) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) chk("midreset_no_pulse", 128'(out_valid), 128'(0));
    end
    run(vecs[0].ct, vecs[0].k, vecs[0].pt, 21, "after_reset");

    last_k = vecs[0].k;
    cached = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      k = (n % 4 == 3) ? last_k : {$urandom, $urandom, $urandom, $urandom};
      run(enc(p, k), k, p, (cached && k == last_k) ? 11 : 21, "loopback");
      last_k = k;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
